sfu_seq_ctrl: RTL and testbench

Controller that sequences one output-tile reduction through the sfu accumulator.
- On start, clears the sfu, then streams kij_len*nij_len partial sums from the shared psum SRAM into the sfu. The psum SRAM is arbitrated by req/gnt.
- Waits for the sfu to report completion, then writes the mij_len ReLU'd results back to the output SRAM, one word per cycle.
- Sits between the core's psum SRAM, the sfu instance and the output SRAM; driven by the top-level testbench/controller.

---
 rtl/sfu_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_sfu_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_seq_ctrl.sv
// sfu_seq_ctrl: sequences one output-tile reduction (clear sfu, stream psums, await result, write back).
// Build option: define SFU_SEQ_STALL_CNT_EN to build the psum-SRAM arbitration stall counter.
module sfu_seq_ctrl #(
    parameter int kij_len = 9,
    parameter int nij_len = 36,
    parameter int mij_len = 16,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [addr_bw-1:0]         rd_base,
    input  logic [addr_bw-1:0]         wr_base,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_req,
    input  logic                       rd_gnt,
    output logic [addr_bw-1:0]         rd_addr,
    input  logic [psum_bw-1:0]         rd_data,
    output logic                       sfu_clr,
    output logic [psum_bw-1:0]         sfu_in,
    output logic                       sfu_valid,
    input  logic                       sfu_o_valid,
    input  logic [mij_len*psum_bw-1:0] sfu_out,
    output logic                       wr_en,
    output logic [addr_bw-1:0]         wr_addr,
    output logic [psum_bw-1:0]         wr_data,
    output logic [15:0]                stall_cnt
);
    localparam int N_RD  = kij_len * nij_len;
    localparam int ISS_W = $clog2(N_RD + 1);
    localparam int WR_W  = $clog2(mij_len + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [addr_bw-1:0] r_rd_base;
    logic [addr_bw-1:0] r_wr_base;
    logic [ISS_W-1:0]   r_issue_cnt;
    logic [WR_W-1:0]    r_wr_cnt;
    logic               w_accept;
    logic               w_issue;
    logic               w_last_issue;
    logic               w_wr_go;
    logic               w_wr_last;
    logic [psum_bw-1:0] w_wr_word;
    logic               r_vld_p1;
    logic               r_wr_en_p1;
    logic [addr_bw-1:0] r_wr_addr_p1;
    logic [psum_bw-1:0] r_wr_data_p1;

    assign w_issue      = rd_req && rd_gnt;
    assign w_last_issue = w_issue && (r_issue_cnt == ISS_W'(N_RD - 1));
    assign w_wr_last    = (r_wr_cnt == WR_W'(mij_len - 1));
    assign w_wr_word    = sfu_out[psum_bw*int'(r_wr_cnt) +: psum_bw];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_STREAM;
            S_STREAM: if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_WAIT;
            S_WAIT:   if (sfu_o_valid) w_next = S_WRITE;
            S_WRITE:  if (w_wr_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b1;
        done     = 1'b0;
        rd_req   = 1'b0;
        sfu_clr  = 1'b0;
        w_accept = 1'b0;
        w_wr_go  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                w_accept = start;
            end
            S_CLEAR:  sfu_clr = 1'b1;
            S_STREAM: rd_req  = 1'b1;
            S_WRITE:  w_wr_go = 1'b1;
            S_DONE:   done    = 1'b1;
            default:  busy    = 1'b1;
        endcase
    end

    // Stage p0 -> p1: issue becomes sfu_valid; write slot becomes the registered SRAM write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_base    <= '0;
            r_wr_base    <= '0;
            r_issue_cnt  <= '0;
            r_wr_cnt     <= '0;
            r_vld_p1     <= 1'b0;
            r_wr_en_p1   <= 1'b0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
        end else begin
            r_vld_p1   <= w_issue;
            r_wr_en_p1 <= w_wr_go;
            if (w_accept) begin
                r_rd_base   <= rd_base;
                r_wr_base   <= wr_base;
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end
            if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_wr_go) begin
                r_wr_addr_p1 <= r_wr_base + addr_bw'(r_wr_cnt);
                r_wr_data_p1 <= w_wr_word;
                r_wr_cnt     <= r_wr_cnt + 1'b1;
            end
        end
    end

    assign rd_addr   = r_rd_base + addr_bw'(r_issue_cnt);
    assign sfu_valid = r_vld_p1;
    assign sfu_in    = r_vld_p1 ? rd_data : '0;
    assign wr_en     = r_wr_en_p1;
    assign wr_addr   = r_wr_addr_p1;
    assign wr_data   = r_wr_data_p1;

`ifdef SFU_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts cycles the read request waited on the arbiter; kept after done for readout.
    always_ff @(posedge clk) begin
        if (reset)                 r_stall_cnt <= '0;
        else if (w_accept)         r_stall_cnt <= '0;
        else if (rd_req && !rd_gnt) r_stall_cnt <= sat_inc16(r_stall_cnt);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Self-checking bench for sfu_seq_ctrl: SRAM/sfu models, event monitor, per-scenario tasks.
module tb_sfu_seq_ctrl;
    localparam int NRD = 324;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] rd_base = '0;
    logic [10:0] wr_base = '0;
    logic        busy, done, rd_req;
    logic        rd_gnt = 1'b1;
    logic [10:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        sfu_clr;
    logic [15:0] sfu_in;
    logic        sfu_valid;
    logic        sfu_o_valid = 1'b0;
    logic [255:0] sfu_out = '0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] stall_cnt;

    sfu_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rd_base(rd_base), .wr_base(wr_base),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
        .rd_data(rd_data), .sfu_clr(sfu_clr), .sfu_in(sfu_in), .sfu_valid(sfu_valid),
        .sfu_o_valid(sfu_o_valid), .sfu_out(sfu_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit gnt_rand = 1'b0;
    logic [15:0] seed = 16'h1357;
    logic [15:0] r_pend = 16'hBEEF;

    logic [10:0] q_rd[$];
    int          q_isc[$];
    logic [15:0] q_sv[$];
    int          q_svc[$];
    logic [10:0] q_wa[$];
    logic [15:0] q_wd[$];
    int          q_wc[$];
    int n_stall, n_hold_bad, n_in_bad, n_clr, clr_cyc, n_done, done_cyc, n_busy_bad, start_cyc;
    bit prev_stall;
    logic [10:0] prev_addr;
    int svn = 0;
    int tmr = 0;

    function automatic logic [15:0] psum_of(input logic [10:0] a);
        return ({5'b0, a} * 16'd37) ^ seed;
    endfunction

    task automatic clear_mon();
        q_rd.delete(); q_isc.delete(); q_sv.delete(); q_svc.delete();
        q_wa.delete(); q_wd.delete(); q_wc.delete();
        n_stall = 0; n_hold_bad = 0; n_in_bad = 0; n_clr = 0; clr_cyc = -1;
        n_done = 0; done_cyc = -1; n_busy_bad = 0; prev_stall = 1'b0;
    endtask

    // psum SRAM: one-cycle read latency
    always @(posedge clk) rd_data <= r_pend;

    // Monitor plus sfu model, sampled mid-cycle
    always @(negedge clk) begin
        #1;
        if (rd_req && rd_gnt) begin
            q_rd.push_back(rd_addr);
            q_isc.push_back(cyc);
            r_pend = psum_of(rd_addr);
        end
        if (prev_stall && rd_req && rd_addr !== prev_addr) n_hold_bad++;
        if (rd_req && !rd_gnt) n_stall++;
        prev_stall = rd_req && !rd_gnt;
        prev_addr  = rd_addr;
        if (sfu_valid) begin
            q_sv.push_back(sfu_in);
            q_svc.push_back(cyc);
        end else if (sfu_in !== 16'd0) n_in_bad++;
        if (sfu_clr) begin n_clr++; clr_cyc = cyc; end
        if (wr_en) begin
            q_wa.push_back(wr_addr); q_wd.push_back(wr_data); q_wc.push_back(cyc);
        end
        if (done) begin
            n_done++; done_cyc = cyc;
            if (busy !== 1'b1) n_busy_bad++;
        end
        if (reset || sfu_clr) begin
            svn = 0; tmr = 0; sfu_o_valid = 1'b0;
        end else begin
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) sfu_o_valid = 1'b1;
            end
            if (sfu_valid) begin
                svn++;
                if (svn == NRD) tmr = 3;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Deviation count of the recorded tile against the ideal tile for these bases.
    function automatic int tile_errs(input logic [10:0] rb, input logic [10:0] wb);
        int e = 0;
        if (q_rd.size() != NRD) e++;
        for (int i = 0; i < q_rd.size(); i++) if (q_rd[i] !== 11'(rb + 11'(i))) e++;
        if (q_sv.size() != NRD) e++;
        for (int i = 0; i < q_sv.size() && i < NRD && i < q_isc.size(); i++) begin
            if (q_sv[i] !== psum_of(11'(rb + 11'(i)))) e++;
            if (q_svc[i] != q_isc[i] + 1) e++;
        end
        if (n_in_bad != 0 || n_hold_bad != 0 || n_busy_bad != 0) e++;
        if (n_clr != 1 || clr_cyc != start_cyc + 1) e++;
        if (q_wa.size() != 16) e++;
        for (int k = 0; k < q_wa.size() && k < 16; k++) begin
            if (q_wa[k] !== 11'(wb + 11'(k))) e++;
            if (q_wd[k] !== sfu_out[k*16 +: 16]) e++;
            if (q_wc[k] != done_cyc - 15 + k) e++;
        end
        if (n_done != 1) e++;
        if (done_cyc - start_cyc != 346 + n_stall) e++;
        return e;
    endfunction

    task automatic launch(input logic [10:0] rb, input logic [10:0] wb);
        @(negedge clk);
        clear_mon();
        seed = 16'($urandom);
        sfu_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b1; rd_base = rb; wr_base = wb; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; rd_base = 11'($urandom); wr_base = 11'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        #2;
    endtask

    task automatic wait_reads(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q_rd.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, rd_req, sfu_clr, sfu_valid, wr_en} !== 6'b0) begin
            n_errors++; $display("FAIL reset_ctrl got=%b want=000000", {busy, done, rd_req, sfu_clr, sfu_valid, wr_en});
        end
        n_checks++;
        if (rd_addr !== 11'd0 || wr_addr !== 11'd0) begin
            n_errors++; $display("FAIL reset_addr rd_addr=%h wr_addr=%h want 0", rd_addr, wr_addr);
        end
        n_checks++;
        if (sfu_in !== 16'd0 || wr_data !== 16'd0 || stall_cnt !== 16'd0) begin
            n_errors++; $display("FAIL reset_data sfu_in=%h wr_data=%h stall=%h want 0", sfu_in, wr_data, stall_cnt);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        int e;
        logic [10:0] last_rd;
        gnt_rand = 1'b0;
        launch(11'h100, 11'h040);
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) begin n_errors++; $display("FAIL basic_done_timeout got=%b want=1", ok); end
        n_checks++;
        if (q_rd.size() != NRD) begin n_errors++; $display("FAIL basic_reads got=%0d want=%0d", q_rd.size(), NRD); end
        last_rd = (q_rd.size() == NRD) ? q_rd[NRD-1] : 11'h7FF;
        n_checks++;
        if (last_rd !== 11'h243) begin n_errors++; $display("FAIL basic_last_rd got=%h want=243", last_rd); end
        n_checks++;
        if (done_cyc - start_cyc != 346) begin
            n_errors++; $display("FAIL basic_latency got=%0d want=346", done_cyc - start_cyc);
        end
        e = tile_errs(11'h100, 11'h040);
        n_checks++;
        if (e != 0) begin n_errors++; $display("FAIL basic_tile deviations=%0d want=0", e); end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL basic_stall got=%0d want=0", stall_cnt); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_fall got=%b want=0", busy); end
    endtask

    task automatic test_random_gnt();
        bit ok;
        int e;
        logic [10:0] rb, wb;
        logic [15:0] exp_stall;
        rb = 11'($urandom); wb = 11'($urandom);
        gnt_rand = 1'b1;
        launch(rb, wb);
        wait_done(ok);
        gnt_rand = 1'b0;
`ifdef SFU_SEQ_STALL_CNT_EN
        exp_stall = 16'(n_stall);
`else
        exp_stall = 16'd0;
`endif
        e = tile_errs(rb, wb);
        n_checks++;
        if (ok !== 1'b1 || e != 0) begin n_errors++; $display("FAIL rgnt_tile done=%b deviations=%0d want 1/0", ok, e); end
        n_checks++;
        if (stall_cnt !== exp_stall) begin n_errors++; $display("FAIL rgnt_stall got=%0d want=%0d", stall_cnt, exp_stall); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (stall_cnt !== exp_stall) begin n_errors++; $display("FAIL rgnt_stall_hold got=%0d want=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_start_ignored();
        bit ok, okw;
        int e;
        gnt_rand = 1'b0;
        launch(11'h200, 11'h300);
        wait_reads(50, ok);
        start = 1'b1; rd_base = 11'h555; wr_base = 11'h666;
        @(negedge clk);
        start = 1'b0;
        okw = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q_wa.size() >= 3) begin okw = 1'b1; break; end
        end
        start = 1'b1; rd_base = 11'h555; wr_base = 11'h666;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ((ok & okw) !== 1'b1) begin n_errors++; $display("FAIL ign_progress got=%b%b want=11", ok, okw); end
        wait_done(ok);
        e = tile_errs(11'h200, 11'h300);
        n_checks++;
        if (ok !== 1'b1 || e != 0) begin n_errors++; $display("FAIL ign_tile done=%b deviations=%0d want 1/0", ok, e); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_clr != 1 || n_done != 1) begin
            n_errors++; $display("FAIL ign_requeue busy=%b clr=%0d done=%0d want 0/1/1", busy, n_clr, n_done);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int e;
        gnt_rand = 1'b0;
        launch(11'h100, 11'h040);
        wait_reads(100, ok);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || {busy, done, rd_req, sfu_clr, sfu_valid, wr_en} !== 6'b0) begin
            n_errors++; $display("FAIL midrst_ctrl got=%b want=000000", {busy, done, rd_req, sfu_clr, sfu_valid, wr_en});
        end
        n_checks++;
        if (rd_addr !== 11'd0 || wr_addr !== 11'd0 || sfu_in !== 16'd0 || wr_data !== 16'd0 || stall_cnt !== 16'd0) begin
            n_errors++; $display("FAIL midrst_data rd_addr=%h wr_addr=%h sfu_in=%h wr_data=%h stall=%h want 0",
                                 rd_addr, wr_addr, sfu_in, wr_data, stall_cnt);
        end
        reset = 1'b0;
        clear_mon();
        repeat (400) @(negedge clk);
        n_checks++;
        if (q_wa.size() != 0 || n_done != 0 || busy !== 1'b0 || q_rd.size() != 0) begin
            n_errors++; $display("FAIL midrst_quiet writes=%0d dones=%0d reads=%0d busy=%b want 0", q_wa.size(), n_done, q_rd.size(), busy);
        end
        launch(11'h155, 11'h0AA);
        wait_done(ok);
        e = tile_errs(11'h155, 11'h0AA);
        n_checks++;
        if (ok !== 1'b1 || e != 0) begin n_errors++; $display("FAIL midrst_retile done=%b deviations=%0d want 1/0", ok, e); end
    endtask

    task automatic test_wrap();
        bit ok;
        int e;
        logic [10:0] last_rd;
        gnt_rand = 1'b0;
        launch(11'h7F0, 11'h7F8);
        wait_done(ok);
        e = tile_errs(11'h7F0, 11'h7F8);
        last_rd = (q_rd.size() == NRD) ? q_rd[NRD-1] : 11'h7FF;
        n_checks++;
        if (ok !== 1'b1 || e != 0) begin n_errors++; $display("FAIL wrap_tile done=%b deviations=%0d want 1/0", ok, e); end
        n_checks++;
        if (last_rd !== 11'h133) begin n_errors++; $display("FAIL wrap_last_rd got=%h want=133", last_rd); end
    endtask

    task automatic test_back_to_back();
        bit ok_a, ok_b;
        int e_a, e_b;
        gnt_rand = 1'b0;
        launch(11'h010, 11'h020);
        wait_done(ok_a);
        e_a = tile_errs(11'h010, 11'h020);
        launch(11'h400, 11'h500);
        wait_done(ok_b);
        e_b = tile_errs(11'h400, 11'h500);
        n_checks++;
        if (ok_a !== 1'b1 || e_a != 0) begin n_errors++; $display("FAIL b2b_first done=%b deviations=%0d want 1/0", ok_a, e_a); end
        n_checks++;
        if (ok_b !== 1'b1 || e_b != 0) begin n_errors++; $display("FAIL b2b_second done=%b deviations=%0d want 1/0", ok_b, e_b); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random_gnt();
        test_random_gnt();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
